// File: rtl/flt_mc_if.sv
// rtl/flt_mc_if.sv - Sample stream, result and coefficient-write signal bundle for flt_mc
interface flt_mc_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 32,
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24,
    parameter int CH_WIDTH   = 1
);
    logic                  WrEn_SI;
    logic [ADDR_WIDTH-1:0] Addr_DI;
    logic [MEM_WIDTH-1:0]  PAR_In_DI;
    logic                  In_Valid_SI;
    logic                  In_Ready_SO;
    logic [CH_WIDTH-1:0]   In_Ch_DI;
    logic [IN_WIDTH-1:0]   In_D_DI;
    logic                  Out_Valid_SO;
    logic [CH_WIDTH-1:0]   Out_Ch_DO;
    logic [OUT_WIDTH-1:0]  Out_D_DO;
    logic                  Ovf_SO;

    modport master (
        output WrEn_SI, Addr_DI, PAR_In_DI, In_Valid_SI, In_Ch_DI, In_D_DI,
        input  In_Ready_SO, Out_Valid_SO, Out_Ch_DO, Out_D_DO, Ovf_SO
    );

    modport slave (
        input  WrEn_SI, Addr_DI, PAR_In_DI, In_Valid_SI, In_Ch_DI, In_D_DI,
        output In_Ready_SO, Out_Valid_SO, Out_Ch_DO, Out_D_DO, Ovf_SO
    );
endinterface

// File: rtl/flt_mc.sv
// rtl/flt_mc.sv - Time-multiplexed multi-channel FIR with one shared MAC, round-half-up output
// Optional output saturation and overflow pulse enabled by defining FLT_MC_SAT_EN.
module flt_mc #(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 32,
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24,
    parameter int COF_WIDTH  = 32,
    parameter int FRAC_BITS  = 30,
    parameter int N_CH       = 2,
    parameter int N_TAPS     = 8
) (
    input  logic     Clk_CI,
    input  logic     Rst_RBI,
    flt_mc_if.slave  bus
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TAP_W = $clog2(N_TAPS);
    localparam int PW    = IN_WIDTH + COF_WIDTH;
    localparam int ACC_W = PW + TAP_W;
    localparam int RW    = ACC_W + 1;
    localparam logic signed [RW-1:0] RND = RW'(1) << (FRAC_BITS - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                       state_q, state_d;
    logic signed [COF_WIDTH-1:0]  coef_q [N_CH][N_TAPS];
    logic signed [IN_WIDTH-1:0]   x_q    [N_CH][N_TAPS];
    logic [TAP_W-1:0]             tap_q, tap_d;
    logic [CH_W-1:0]              ch_q, ch_d, out_ch_q, out_ch_d;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [OUT_WIDTH-1:0]         out_d_q, out_d_d, res_o;
    logic                         out_valid_q, out_valid_d, ovf_q, ovf_d, res_ovf;
    logic                         accept, ch_ok;
    logic signed [PW-1:0]         prod;
    logic signed [RW-1:0]         rnd, res;

    generate
        if ((1 << CH_W) > N_CH) begin : g_ch_chk
            assign ch_ok = (bus.In_Ch_DI < CH_W'(N_CH));
        end else begin : g_ch_all
            assign ch_ok = 1'b1;
        end
    endgenerate

    assign prod = PW'(x_q[ch_q][tap_q]) * PW'(coef_q[ch_q][tap_q]);
    assign rnd  = RW'(acc_q) + RND;
    assign res  = rnd >>> FRAC_BITS;

`ifdef FLT_MC_SAT_EN
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        res_o   = res[OUT_WIDTH-1:0];
        res_ovf = 1'b0;
        if (res > SAT_MAX) begin
            res_o   = SAT_MAX[OUT_WIDTH-1:0];
            res_ovf = 1'b1;
        end else if (res < SAT_MIN) begin
            res_o   = SAT_MIN[OUT_WIDTH-1:0];
            res_ovf = 1'b1;
        end
    end
`else
    logic unused_res;
    assign unused_res = ^res[RW-1:OUT_WIDTH];
    assign res_o      = res[OUT_WIDTH-1:0];
    assign res_ovf    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        out_d_d     = out_d_q;
        out_ch_d    = out_ch_q;
        out_valid_d = 1'b0;
        ovf_d       = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                // Out-of-range channels still complete the handshake but are dropped here.
                if (bus.In_Valid_SI && ch_ok) begin
                    accept  = 1'b1;
                    acc_d   = '0;
                    tap_d   = '0;
                    ch_d    = bus.In_Ch_DI;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                tap_d = tap_q + TAP_W'(1);
                if (tap_q == TAP_W'(N_TAPS - 1)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid_d = 1'b1;
                out_ch_d    = ch_q;
                out_d_d     = res_o;
                ovf_d       = res_ovf;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            tap_q       <= '0;
            ch_q        <= '0;
            acc_q       <= '0;
            out_d_q     <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                for (int t = 0; t < N_TAPS; t++) begin
                    coef_q[c][t] <= '0;
                    x_q[c][t]    <= '0;
                end
            end
        end else begin
            tap_q       <= tap_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            out_d_q     <= out_d_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            for (int c = 0; c < N_CH; c++) begin
                for (int t = 0; t < N_TAPS; t++) begin
                    if (bus.WrEn_SI && bus.Addr_DI == ADDR_WIDTH'(c * N_TAPS + t)) begin
                        coef_q[c][t] <= bus.PAR_In_DI[COF_WIDTH-1:0];
                    end
                end
                if (accept && bus.In_Ch_DI == CH_W'(c)) begin
                    for (int t = N_TAPS - 1; t > 0; t--) begin
                        x_q[c][t] <= x_q[c][t-1];
                    end
                    x_q[c][0] <= bus.In_D_DI;
                end
            end
        end
    end

    assign bus.In_Ready_SO  = (state_q == IDLE);
    assign bus.Out_Valid_SO = out_valid_q;
    assign bus.Out_Ch_DO    = out_ch_q;
    assign bus.Out_D_DO     = out_d_q;
    assign bus.Ovf_SO       = ovf_q;
endmodule

// File: tb/tb_flt_mc.sv
// tb/tb_flt_mc.sv - Directed and randomized bench for flt_mc against an arithmetic FIR model
module tb_flt_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    longint      coef_m [16];
    longint      hist   [2][8];
    logic [23:0] exp_d;
    logic        exp_ovf;

    flt_mc_if #(.ADDR_WIDTH(5), .MEM_WIDTH(32), .IN_WIDTH(24), .OUT_WIDTH(24), .CH_WIDTH(1)) bus ();

    flt_mc u_dut (
        .Clk_CI  (clk),
        .Rst_RBI (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int a = 0; a < 16; a++) coef_m[a] = 0;
        for (int c = 0; c < 2; c++)
            for (int t = 0; t < 8; t++) hist[c][t] = 0;
    endtask

    task automatic push(input int ch, input int d);
        logic [23:0] s;
        s = d[23:0];
        for (int t = 7; t > 0; t--) hist[ch][t] = hist[ch][t-1];
        hist[ch][0] = longint'($signed(s));
    endtask

    // Expected result: dot product, round half up at 2^-30, then clamp or wrap to 24 bits.
    task automatic calc_exp(input int ch);
        longint acc;
        longint r;
        acc = 0;
        for (int t = 0; t < 8; t++) acc += hist[ch][t] * coef_m[ch*8 + t];
        r = (acc + 64'sd536870912) >>> 30;
        exp_d   = r[23:0];
        exp_ovf = 1'b0;
`ifdef FLT_MC_SAT_EN
        if (r > 64'sd8388607) begin
            exp_d   = 24'h7FFFFF;
            exp_ovf = 1'b1;
        end else if (r < -64'sd8388608) begin
            exp_d   = 24'h800000;
            exp_ovf = 1'b1;
        end
`endif
    endtask

    task automatic wr_coef(input int a, input int d);
        @(negedge clk);
        bus.WrEn_SI   = 1'b1;
        bus.Addr_DI   = a[4:0];
        bus.PAR_In_DI = d;
        @(negedge clk);
        bus.WrEn_SI   = 1'b0;
        if (a < 16) coef_m[a] = longint'(d);
    endtask

    task automatic send(input int ch, input int d, input bit do_wr, input int wa, input int wd,
                        output logic [23:0] got);
        int lat;
        @(negedge clk);
        check("in_ready", bus.In_Ready_SO, 1'b1);
        bus.In_Valid_SI = 1'b1;
        bus.In_Ch_DI    = ch[0:0];
        bus.In_D_DI     = d[23:0];
        if (do_wr) begin
            bus.WrEn_SI   = 1'b1;
            bus.Addr_DI   = wa[4:0];
            bus.PAR_In_DI = wd;
        end
        @(negedge clk);
        bus.In_Valid_SI = 1'b0;
        bus.WrEn_SI     = 1'b0;
        if (do_wr && wa < 16) coef_m[wa] = longint'(wd);
        push(ch, d);
        calc_exp(ch);
        lat = 1;
        while (!bus.Out_Valid_SO && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 10);
        got = bus.Out_D_DO;
        check("out_d", bus.Out_D_DO, exp_d);
        check("out_ch", bus.Out_Ch_DO, ch);
        check("ovf", bus.Ovf_SO, exp_ovf);
        @(negedge clk);
        check("valid_pulse", bus.Out_Valid_SO, 1'b0);
        check("out_hold", bus.Out_D_DO, exp_d);
    endtask

    initial begin
        logic [23:0] got;
        logic [23:0] hs_exp;
        int          st_ch [11];
        int          st_d  [11];
        logic [23:0] st_e  [11];
        int          last_acc, pend, n_acc, n_out, seen;

        bus.WrEn_SI = 1'b0; bus.Addr_DI = '0; bus.PAR_In_DI = '0;
        bus.In_Valid_SI = 1'b0; bus.In_Ch_DI = '0; bus.In_D_DI = '0;
        clear_model();
        repeat (2) @(negedge clk);
        check("rst_ready", bus.In_Ready_SO, 1'b1);
        check("rst_valid", bus.Out_Valid_SO, 1'b0);
        check("rst_ovf", bus.Ovf_SO, 1'b0);
        check("rst_out_d", bus.Out_D_DO, 24'd0);
        check("rst_out_ch", bus.Out_Ch_DO, 1'b0);
        rst_n = 1'b1;

        // Impulse on ch0
        for (int t = 0; t < 8; t++) wr_coef(t, (t + 1) * (1 << 26));
        send(0, 1600, 1'b0, 0, 0, got);
        check("impulse0", got, 24'd100);
        for (int k = 1; k < 9; k++) begin
            send(0, 0, 1'b0, 0, 0, got);
            check("impulse", got, (k < 8) ? 100 * (k + 1) : 0);
        end

        // Channel isolation: ch1 identity interleaved with the ch0 impulse
        wr_coef(8, 1 << 30);
        st_ch = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        st_d  = '{1600, 5, 0, -7, 0, 0, 0, 0, 0, 0, 0};
        st_e  = '{24'd100, 24'd5, 24'd200, 24'hFFFFF9, 24'd300, 24'd400,
                  24'd500, 24'd600, 24'd700, 24'd800, 24'd0};
        for (int k = 0; k < 11; k++) begin
            send(st_ch[k], st_d[k], 1'b0, 0, 0, got);
            check("isolation", got, st_e[k]);
        end

        // Out-of-range coefficient writes leave the bank untouched
        for (int a = 16; a < 32; a++) wr_coef(a, int'($urandom));
        send(1, 1234, 1'b0, 0, 0, got);
        check("oor_ch1", got, 24'd1234);
        send(0, 1600, 1'b0, 0, 0, got);
        check("oor_ch0", got, 24'd100);

        // Valid held high: spacing and latency of back-to-back acceptances
        @(negedge clk);
        bus.In_Valid_SI = 1'b1; bus.In_Ch_DI = 1'b0; bus.In_D_DI = 24'd777;
        last_acc = -1; pend = -1; n_acc = 0; n_out = 0; hs_exp = '0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.Out_Valid_SO) begin
                n_out++;
                check("hs_latency", cyc - pend, 9);
                check("hs_out_d", bus.Out_D_DO, hs_exp);
            end
            if (bus.In_Ready_SO && bus.In_Valid_SI) begin
                if (n_acc < 3) begin
                    n_acc++;
                    if (last_acc >= 0) check("hs_gap", cyc + 1 - last_acc, 10);
                    last_acc = cyc + 1;
                    pend     = cyc + 1;
                    push(0, 777);
                    calc_exp(0);
                    hs_exp = exp_d;
                end else begin
                    bus.In_Valid_SI = 1'b0;
                end
            end
        end
        bus.In_Valid_SI = 1'b0;
        check("hs_outputs", n_out, 3);

        // Saturation / wrap
        for (int t = 1; t < 8; t++) wr_coef(t, 0);
        wr_coef(0, 32'h7FFFFFFF);
        send(0, 8388607, 1'b0, 0, 0, got);
`ifdef FLT_MC_SAT_EN
        check("sat_value", got, 24'h7FFFFF);
`else
        check("wrap_value", got, 24'hFFFFFE);
`endif

        // Rounding, half up
        wr_coef(0, 1 << 29);
        send(0, 3, 1'b0, 0, 0, got);
        check("round_p3", got, 24'd2);
        send(0, -3, 1'b0, 0, 0, got);
        check("round_m3", got, 24'hFFFFFF);
        send(0, -4, 1'b0, 0, 0, got);
        check("round_m4", got, 24'hFFFFFE);

        // Randomized traffic, with coefficient writes sometimes landing on the acceptance edge
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) wr_coef($urandom_range(0, 31), int'($urandom));
            send($urandom_range(0, 1), int'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 31), int'($urandom), got);
        end

        // Reset while the MAC is busy
        @(negedge clk);
        bus.In_Valid_SI = 1'b1; bus.In_Ch_DI = 1'b0; bus.In_D_DI = 24'd1600;
        @(negedge clk);
        bus.In_Valid_SI = 1'b0;
        check("busy_ready", bus.In_Ready_SO, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", bus.In_Ready_SO, 1'b1);
        check("mid_rst_valid", bus.Out_Valid_SO, 1'b0);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (bus.Out_Valid_SO) seen = 1;
        end
        check("mid_rst_no_out", seen, 0);
        check("post_rst_ready", bus.In_Ready_SO, 1'b1);
        clear_model();
        send(0, 1600, 1'b0, 0, 0, got);
        check("post_rst_impulse", got, 24'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
